fc_layer_tm: RTL
================

FC_LAYER_TM -- requirements
Module: fc_layer_tm

Interface
REQ-001 SHALL have parameter NUM_NEURON, default 10, number of neurons in the layer.
REQ-002 SHALL have parameter NUM_INPUT, default 30, inputs (weights) per neuron.
REQ-003 SHALL have parameter LANES, default 2, parallel MAC lanes, 1 <= LANES <= NUM_NEURON.
REQ-004 SHALL have parameter DATA_WIDTH, default 16, signed fixed-point word width.
REQ-005 SHALL have parameter FRAC_WIDTH, default 8, fractional bits of data, weight and bias.
REQ-006 SHALL have parameter LAYER_NUM, default 4, layer ID matched against config_layer_num.
REQ-007 SHALL have parameter ACT_TYPE, default "relu", activation type ("relu" or "none").
REQ-008 SHALL have port clk  in  1  single clock, rising edge.
REQ-009 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-010 SHALL have ports weightValid / biasValid  in  1 each  weight / bias write strobes.
REQ-011 SHALL have ports weightValue / biasValue  in  32 each  write data; bits [DATA_WIDTH-1:0] used.
REQ-012 SHALL have ports config_layer_num / config_neuron_num  in  32 each  write target.
REQ-013 SHALL have ports x_valid  in  1, x_ready  out  1, x_in  in  DATA_WIDTH  input stream.
REQ-014 SHALL have ports o_valid  out  1, o_ready  in  1, o_data  out  DATA_WIDTH  output stream.
REQ-015 SHALL have port o_index  out  clog2(NUM_NEURON)  neuron number of o_data.
REQ-016 SHALL have port busy  out  1  high in any state except IDLE.

Function
REQ-017 SHALL implement states IDLE, MAC, FIN, OUT; x_ready=1 only in IDLE; o_valid=1 only in OUT.
REQ-018 IDLE: each x_valid&x_ready beat SHALL store x_in at input index 0..NUM_INPUT-1 in order; the beat at index NUM_INPUT-1 SHALL move to MAC next cycle.
REQ-019 Weight write: weightValid with config_layer_num==LAYER_NUM and state IDLE SHALL write W[config_neuron_num][wptr], wptr incrementing and wrapping NUM_INPUT-1 -> 0; wptr SHALL reset to 0 whenever config_neuron_num differs from the value at the previous accepted write.
REQ-020 Bias write: biasValid with matching layer in IDLE SHALL write B[config_neuron_num]; writes in other states, with other layers, or with neuron number >= NUM_NEURON SHALL be ignored.
REQ-021 Neurons SHALL be processed in groups of LANES (G = ceil(NUM_NEURON/LANES)); group g lane l computes neuron g*LANES+l; lanes beyond NUM_NEURON-1 SHALL be discarded.
REQ-022 MAC: exactly NUM_INPUT cycles per group, lane acc += x[i]*W[n][i], i = 0..NUM_INPUT-1; product 2*DATA_WIDTH signed, accumulator 2*DATA_WIDTH+clog2(NUM_INPUT) bits, no overflow possible.
REQ-023 FIN: one cycle per group; result = (acc + (B<<FRAC_WIDTH)) >>> FRAC_WIDTH (arithmetic, truncation), saturated to signed DATA_WIDTH range; then ReLU (negative -> 0) if ACT_TYPE="relu"; stored to result register n; accumulators cleared.
REQ-024 After FIN of the last group, state SHALL be OUT; else MAC of next group.
REQ-025 Latency: last input accepted at cycle T -> o_valid first high at T+1+G*(NUM_INPUT+1).
REQ-026 OUT: o_data/o_index present neuron 0..NUM_NEURON-1 in order; advance only on o_valid&o_ready; o_data/o_index SHALL hold stable while o_ready=0.
REQ-027 Handshake on index NUM_NEURON-1 SHALL return to IDLE next cycle, input index reset to 0.
REQ-028 Weight/bias memories SHALL retain contents across inference runs and across reset.

Reset
REQ-029 rst=1 SHALL asynchronously force IDLE, x_ready=1, o_valid=0, o_data=0, o_index=0, busy=0, all counters, accumulators and wptr to 0, aborting any run in progress.
REQ-030 W and B SHALL NOT be cleared by reset; input buffer and result registers need no reset.

Verification (NUM_NEURON=3, NUM_INPUT=4, LANES=2, DATA_WIDTH=16, FRAC_WIDTH=8, relu)
REQ-031 Load N0 W=0x0080x4, B=0x0040; N1 W=0xFF00x4, B=0; N2 W=0x0100x4, B=0xFF00; x=0x0100x4 -> outputs 0x0240, 0x0000, 0x0300 at o_index 0,1,2, first o_valid at T+11.
REQ-032 Same with ACT_TYPE="none" -> N1 output 0xFC00.
REQ-033 W=0x7FFF, x=0x7FFF all, B=0x7FFF -> 0x7FFF; W=0x8000, x=0x7FFF -> relu 0x0000, none 0x8000.
REQ-034 o_ready low 5 cycles at index 1 -> o_data/o_index held, no beat lost or duplicated; x_valid during OUT -> x_ready=0, no input stored.
REQ-035 rst pulse during MAC of group 1 -> IDLE, o_valid=0 immediately; fresh run without reloading weights reproduces REQ-031 results.
REQ-036 Weight write with config_layer_num=3 or during MAC -> no memory change; results unchanged.

Source files
------------

// File: rtl/fc_layer_tm.sv
// Time-multiplexed fully connected layer: LANES MAC units sweep the neurons group by group,
// then the results are streamed out in neuron order with a valid/ready handshake.
module fc_layer_tm #(
    parameter int NUM_NEURON = 10,
    parameter int NUM_INPUT  = 30,
    parameter int LANES      = 2,
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_WIDTH = 8,
    parameter int LAYER_NUM  = 4,
    parameter     ACT_TYPE   = "relu"
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          weightValid,
    input  logic                          biasValid,
    input  logic [31:0]                   weightValue,
    input  logic [31:0]                   biasValue,
    input  logic [31:0]                   config_layer_num,
    input  logic [31:0]                   config_neuron_num,
    input  logic                          x_valid,
    output logic                          x_ready,
    input  logic [DATA_WIDTH-1:0]         x_in,
    output logic                          o_valid,
    input  logic                          o_ready,
    output logic [DATA_WIDTH-1:0]         o_data,
    output logic [$clog2(NUM_NEURON)-1:0] o_index,
    output logic                          busy
);
    localparam int IW = $clog2(NUM_NEURON);
    localparam int G  = (NUM_NEURON + LANES - 1) / LANES;
    localparam int XW = (NUM_INPUT > 1) ? $clog2(NUM_INPUT) : 1;
    localparam int GW = (G > 1) ? $clog2(G) : 1;
    localparam int PW = 2 * DATA_WIDTH;
    localparam int AW = PW + $clog2(NUM_INPUT);
    localparam int SW = AW + 1;
    localparam bit RELU = (ACT_TYPE == "relu");
    localparam logic signed [SW-1:0] MAXV = {{(SW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV = {{(SW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, FIN = 2'd2, OUT = 2'd3} state_t;

    state_t                        state;
    logic signed [DATA_WIDTH-1:0]  w_mem [NUM_NEURON][NUM_INPUT];
    logic signed [DATA_WIDTH-1:0]  b_mem [NUM_NEURON];
    logic signed [DATA_WIDTH-1:0]  x_buf [NUM_INPUT];
    logic signed [DATA_WIDTH-1:0]  res   [NUM_NEURON];
    logic signed [AW-1:0]          acc   [LANES];
    logic [XW-1:0]                 x_cnt;
    logic [XW-1:0]                 mac_i;
    logic [GW-1:0]                 grp;
    logic [XW-1:0]                 wptr;
    logic [XW-1:0]                 w_slot;
    logic [31:0]                   last_neuron;
    logic [IW-1:0]                 cfg_n;
    logic [IW-1:0]                 nxt_idx;
    logic                          cfg_hit;
    logic                          w_acc;
    logic                          b_acc;
    logic [IW-1:0]                 lane_n  [LANES];
    logic                          lane_ok [LANES];
    logic signed [PW-1:0]          prod    [LANES];
    logic signed [SW-1:0]          sum_v   [LANES];
    logic signed [SW-1:0]          sh_v    [LANES];
    logic signed [DATA_WIDTH-1:0]  fin_val [LANES];
    logic                          unused_bits;

    assign unused_bits = ^{weightValue[31:DATA_WIDTH], biasValue[31:DATA_WIDTH]};
    assign cfg_n   = config_neuron_num[IW-1:0];
    assign cfg_hit = (state == IDLE) && (config_layer_num == 32'(LAYER_NUM))
                     && (config_neuron_num < 32'(NUM_NEURON));
    assign w_acc   = weightValid && cfg_hit;
    assign b_acc   = biasValid && cfg_hit;
    // A write to a different neuron than last time restarts its weight sequence at slot 0
    assign w_slot  = (config_neuron_num != last_neuron) ? '0 : wptr;
    assign nxt_idx = o_index + 1'b1;

    // Per-lane neuron selection, MAC product and bias/round/saturate/activate result
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_ok[l] = (int'(grp) * LANES + l) < NUM_NEURON;
            lane_n[l]  = lane_ok[l] ? IW'(int'(grp) * LANES + l) : '0;
            prod[l]    = x_buf[mac_i] * w_mem[lane_n[l]][mac_i];
            sum_v[l]   = SW'(acc[l]) + (SW'(b_mem[lane_n[l]]) <<< FRAC_WIDTH);
            sh_v[l]    = sum_v[l] >>> FRAC_WIDTH;
            if (RELU && sh_v[l][SW-1]) begin
                fin_val[l] = '0;
            end else if (sh_v[l] > MAXV) begin
                fin_val[l] = MAXV[DATA_WIDTH-1:0];
            end else if (sh_v[l] < MINV) begin
                fin_val[l] = MINV[DATA_WIDTH-1:0];
            end else begin
                fin_val[l] = sh_v[l][DATA_WIDTH-1:0];
            end
        end
    end

    // Weight pointer bookkeeping for sequential weight loading
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr        <= '0;
            last_neuron <= '0;
        end else if (w_acc) begin
            last_neuron <= config_neuron_num;
            wptr        <= (w_slot == XW'(NUM_INPUT - 1)) ? '0 : w_slot + 1'b1;
        end
    end

    // Unreset storage: parameters survive reset, buffers are always written before use
    always_ff @(posedge clk) begin
        if (w_acc) w_mem[cfg_n][w_slot] <= weightValue[DATA_WIDTH-1:0];
        if (b_acc) b_mem[cfg_n] <= biasValue[DATA_WIDTH-1:0];
        if (state == IDLE && x_valid) x_buf[x_cnt] <= x_in;
        if (state == FIN) begin
            for (int l = 0; l < LANES; l++) begin
                if (lane_ok[l]) res[lane_n[l]] <= fin_val[l];
            end
        end
    end

    // Control FSM with registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            x_cnt   <= '0;
            mac_i   <= '0;
            grp     <= '0;
            for (int l = 0; l < LANES; l++) acc[l] <= '0;
            x_ready <= 1'b1;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_index <= '0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (x_valid) begin
                        if (x_cnt == XW'(NUM_INPUT - 1)) begin
                            x_cnt   <= '0;
                            state   <= MAC;
                            x_ready <= 1'b0;
                            busy    <= 1'b1;
                        end else begin
                            x_cnt <= x_cnt + 1'b1;
                        end
                    end
                end
                MAC: begin
                    for (int l = 0; l < LANES; l++) acc[l] <= acc[l] + AW'(prod[l]);
                    if (mac_i == XW'(NUM_INPUT - 1)) begin
                        mac_i <= '0;
                        state <= FIN;
                    end else begin
                        mac_i <= mac_i + 1'b1;
                    end
                end
                FIN: begin
                    for (int l = 0; l < LANES; l++) acc[l] <= '0;
                    if (grp == GW'(G - 1)) begin
                        grp     <= '0;
                        state   <= OUT;
                        o_valid <= 1'b1;
                        o_index <= '0;
                        // With a single group neuron 0 is being written this very cycle
                        o_data  <= (G == 1) ? fin_val[0] : res[0];
                    end else begin
                        grp   <= grp + 1'b1;
                        state <= MAC;
                    end
                end
                OUT: begin
                    if (o_ready) begin
                        if (o_index == IW'(NUM_NEURON - 1)) begin
                            state   <= IDLE;
                            o_valid <= 1'b0;
                            o_index <= '0;
                            o_data  <= '0;
                            x_ready <= 1'b1;
                            busy    <= 1'b0;
                        end else begin
                            o_index <= nxt_idx;
                            o_data  <= res[nxt_idx];
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
